ahb_ssram_bridge: RTL and testbench
===================================

AHB_SSRAM_BRIDGE -- requirements
Module: ahb_ssram_bridge

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- AW, 12: byte address width.
- DW, 32: data width; legal values 32 or 64; NB = DW/8 byte lanes.
- RD_LAT, 1: SRAM read latency in cycles; legal values 1 or 2.
REQ-002 Ports (name, direction, width, meaning), one per line:
- HCLK, in, 1: clock.
- HRESETn, in, 1: reset.
- HSEL, in, 1: slave select.
- HADDR, in, AW: byte address.
- HTRANS, in, 2: transfer type.
- HSIZE, in, 3: transfer size.
- HWRITE, in, 1: write when 1.
- HWDATA, in, DW: write data.
- HREADY, in, 1: bus ready.
- HREADYOUT, out, 1: slave ready.
- HRDATA, out, DW: read data.
- HRESP, out, 1: 1 = ERROR.
- sram_addr, out, AW-log2(NB): word address.
- sram_en, out, NB: per-lane enable.
- sram_we, out, NB: per-lane write enable.
- sram_din, out, DW: SRAM write data.
- sram_dout, in, DW: SRAM read data.
REQ-003 The block SHALL use one clock, HCLK; reset HRESETn SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL accept a transfer when HSEL & HREADY & HTRANS[1] are all 1; IDLE and BUSY transfers SHALL get a zero-wait OKAY response and cause no SRAM access.
REQ-005 The block SHALL raise an error for any transfer with HSIZE > log2(NB), or with HADDR not aligned to HSIZE.
REQ-006 An errored transfer SHALL produce a two-cycle ERROR response with no SRAM access:
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
REQ-007 The state machine SHALL have states IDLE, RD_WAIT, ERR1 and ERR2.
- IDLE -> ERR1 on an errored transfer.
- ERR1 -> ERR2 unconditionally.
- ERR2 -> IDLE unconditionally.
- IDLE -> RD_WAIT on an accepted read when RD_LAT=2.
- RD_WAIT -> IDLE after one cycle.
REQ-008 A read SHALL issue in its address-phase cycle: sram_en = all lanes, sram_we = 0, sram_addr = HADDR word index.
REQ-009 Read data SHALL appear in the data phase. RD_LAT=1 gives zero wait states; RD_LAT=2 gives exactly one wait state (HREADYOUT=0 in RD_WAIT).
REQ-010 A write SHALL capture its word address and byte mask in the address phase, where mask = lanes addressed by HADDR[log2(NB)-1:0] and HSIZE. The write response SHALL always be zero-wait OKAY.
REQ-011 In the write data-phase cycle, if no read address phase is accepted that cycle, the write SHALL commit directly: sram_en = sram_we = mask, sram_din = HWDATA.
REQ-012 If the write data phase collides with a read address phase, the read SHALL own the SRAM and the write SHALL be held in a one-entry buffer (address, mask, data, valid).
REQ-013 A buffered write SHALL commit in the first later cycle that has no read address phase and is not RD_WAIT. An incoming write address phase counts as a free cycle, so the buffer SHALL never overflow.
REQ-014 Forwarding SHALL apply when a read word address equals the buffered word address, or equals a write whose data phase coincides with the read address phase. In that case HRDATA lanes in the mask SHALL carry the buffered data and the other lanes SHALL carry sram_dout.
REQ-015 HRDATA SHALL be 0 outside read data phases.
REQ-016 While HREADYOUT=0, the block SHALL not accept new transfers and the buffered write SHALL not commit.

Reset
REQ-017 While HRESETn=0, outputs SHALL be: HREADYOUT=1, HRESP=0, HRDATA=0, sram_en=0, sram_we=0, sram_addr=0, sram_din=0. State SHALL be IDLE and the buffer SHALL be invalid.
REQ-018 A reset asserted mid-transfer SHALL discard any buffered write, which is then never committed, and SHALL abort ERR and RD_WAIT sequences.

Verification (DW=32, AW=12, RD_LAT=1 unless stated)
REQ-019 Word write 0x004=0xDEADBEEF, then an immediate read of 0x004 in the write's data-phase cycle -> HRDATA=0xDEADBEEF with zero wait; the write commits in the next free cycle with sram_addr=0x001.
REQ-020 Byte write HADDR=0x013, HSIZE=0, HWDATA=0xAA000000 -> sram_en=sram_we=4'b1000, sram_addr=0x004, sram_din[31:24]=0xAA.
REQ-021 Word transfer at HADDR=0x002 -> ERROR: HREADYOUT 0 then 1, HRESP=1 for both cycles, sram_en=0 throughout; then a legal read -> OKAY.
REQ-022 RD_LAT=2, read of 0x008 preloaded with 0x12345678 -> one cycle with HREADYOUT=0, then HRDATA=0x12345678 with HREADYOUT=1.
REQ-023 Write 0x020, then four back-to-back reads of 0x040, then IDLE -> the write commits in the IDLE cycle. Repeating the sequence with HRESETn pulsed low before the IDLE -> no commit, outputs at their reset values.

Source files
------------

// File: rtl/ahb_ssram_bridge.sv
// AHB-Lite slave onto a synchronous single-port SRAM with per-byte lane enables.
// Reads take priority on the SRAM; a colliding write waits in a one-entry buffer and is forwarded to reads.
module ahb_ssram_bridge #(
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        HSEL,
  input  logic [AW-1:0]               HADDR,
  input  logic [1:0]                  HTRANS,
  input  logic [2:0]                  HSIZE,
  input  logic                        HWRITE,
  input  logic [DW-1:0]               HWDATA,
  input  logic                        HREADY,
  output logic                        HREADYOUT,
  output logic [DW-1:0]               HRDATA,
  output logic                        HRESP,
  output logic [AW-$clog2(DW/8)-1:0]  sram_addr,
  output logic [DW/8-1:0]             sram_en,
  output logic [DW/8-1:0]             sram_we,
  output logic [DW-1:0]               sram_din,
  input  logic [DW-1:0]               sram_dout,
  output logic [1:0]                  o_dbg_state
);
  localparam int NB  = DW / 8;
  localparam int BW  = $clog2(NB);
  localparam int WAW = AW - BW;

  // Valid/ready: a transfer's address phase completes on a rising edge where
  // HSEL & HREADY & HTRANS[1] are high and this slave drives HREADYOUT=1.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_ERR1    = 2'd2,
    S_ERR2    = 2'd3
  } state_t;

  state_t         r_state, w_state_nxt;
  logic           w_ready_out, w_accept, w_err, w_rd_issue, w_wr_accept;
  logic           w_buf_load, w_buf_commit, w_rd_dp, w_unused;
  logic [NB-1:0]  w_mask, w_fw_mask;
  logic [DW-1:0]  w_fw_data;
  logic [WAW-1:0] w_word;
  logic [BW-1:0]  w_low;

  logic           r_wr_dp, r_buf_vld, r_rd_dp0, r_rd_dp1;
  logic [WAW-1:0] r_wr_addr, r_buf_addr;
  logic [NB-1:0]  r_wr_mask, r_buf_mask, r_fw_mask;
  logic [DW-1:0]  r_buf_data, r_fw_data;

  assign w_unused    = HTRANS[0];
  assign w_word      = HADDR[AW-1:BW];
  assign w_low       = HADDR[BW-1:0];
  assign w_ready_out = (r_state != S_RD_WAIT) && (r_state != S_ERR1);
  assign w_accept    = HRESETn & HSEL & HREADY & HTRANS[1] & w_ready_out;
  assign w_rd_issue  = w_accept & ~w_err & ~HWRITE;
  assign w_wr_accept = w_accept & ~w_err & HWRITE;
  assign w_rd_dp     = (RD_LAT == 2) ? r_rd_dp1 : r_rd_dp0;

  assign HREADYOUT   = w_ready_out;
  assign HRESP       = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign o_dbg_state = r_state;

  always_comb begin
    w_err  = 1'b0;
    w_mask = '0;
    if (HSIZE > 3'(BW)) begin
      w_err = 1'b1;
    end else begin
      for (int i = 0; i < BW; i++)
        if (i < int'(HSIZE) && w_low[i]) w_err = 1'b1;
      for (int i = 0; i < NB; i++)
        w_mask[i] = ((i >> HSIZE) == (int'(w_low) >> HSIZE));
    end
  end

  // A transfer accepted during ERR2 is handled exactly as one accepted in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ERR1:    w_state_nxt = S_ERR2;
      S_RD_WAIT: w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        if (w_accept && w_err)                 w_state_nxt = S_ERR1;
        else if (w_rd_issue && (RD_LAT == 2))  w_state_nxt = S_RD_WAIT;
      end
    endcase
  end

  // The write in its data phase is newer than the buffered one, so it wins per lane.
  always_comb begin
    w_fw_mask = '0;
    w_fw_data = '0;
    for (int i = 0; i < NB; i++) begin
      if (r_wr_dp && (r_wr_addr == w_word) && r_wr_mask[i]) begin
        w_fw_mask[i]         = 1'b1;
        w_fw_data[i*8 +: 8]  = HWDATA[i*8 +: 8];
      end else if (r_buf_vld && (r_buf_addr == w_word) && r_buf_mask[i]) begin
        w_fw_mask[i]         = 1'b1;
        w_fw_data[i*8 +: 8]  = r_buf_data[i*8 +: 8];
      end
    end
  end

  assign w_buf_load   = r_wr_dp & w_rd_issue;
  assign w_buf_commit = r_buf_vld & w_ready_out & ~w_rd_issue & ~r_wr_dp;

  always_comb begin
    sram_addr = '0;
    sram_en   = '0;
    sram_we   = '0;
    sram_din  = '0;
    if (w_rd_issue) begin
      sram_addr = w_word;
      sram_en   = '1;
    end else if (r_wr_dp) begin
      sram_addr = r_wr_addr;
      sram_en   = r_wr_mask;
      sram_we   = r_wr_mask;
      sram_din  = HWDATA;
    end else if (w_buf_commit) begin
      sram_addr = r_buf_addr;
      sram_en   = r_buf_mask;
      sram_we   = r_buf_mask;
      sram_din  = r_buf_data;
    end
  end

  always_comb begin
    HRDATA = '0;
    if (w_rd_dp)
      for (int i = 0; i < NB; i++)
        HRDATA[i*8 +: 8] = r_fw_mask[i] ? r_fw_data[i*8 +: 8] : sram_dout[i*8 +: 8];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= S_IDLE;
      r_wr_dp    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_mask  <= '0;
      r_buf_vld  <= 1'b0;
      r_buf_addr <= '0;
      r_buf_mask <= '0;
      r_buf_data <= '0;
      r_rd_dp0   <= 1'b0;
      r_rd_dp1   <= 1'b0;
      r_fw_mask  <= '0;
      r_fw_data  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_dp  <= w_wr_accept;
      r_rd_dp0 <= w_rd_issue;
      r_rd_dp1 <= r_rd_dp0;
      if (w_wr_accept) begin
        r_wr_addr <= w_word;
        r_wr_mask <= w_mask;
      end
      if (w_buf_load) begin
        r_buf_vld  <= 1'b1;
        r_buf_addr <= r_wr_addr;
        r_buf_mask <= r_wr_mask;
        r_buf_data <= HWDATA;
      end else if (w_buf_commit) begin
        r_buf_vld <= 1'b0;
      end
      if (w_rd_issue) begin
        r_fw_mask <= w_fw_mask;
        r_fw_data <= w_fw_data;
      end
    end
  end
endmodule

// File: tb/tb_ahb_ssram_bridge.sv
// Bench for ahb_ssram_bridge: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=2,
// each with its own SRAM and a byte-level memory model updated in bus order.
module tb_ahb_ssram_bridge;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bus and SRAM wiring ----------------
  logic [1:0]  hsel;
  logic [11:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [1:0]  hreadyout, hresp;
  logic [31:0] hrdata [2];
  logic [9:0]  s_addr [2];
  logic [3:0]  s_en [2];
  logic [3:0]  s_we [2];
  logic [31:0] s_din [2];
  logic [31:0] s_dout [2];
  logic [1:0]  dbg_state_unused [2];
  logic        pl_en, pl_sel;
  logic [5:0]  pl_addr;
  logic [31:0] pl_data;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [0:63];
    logic [31:0] rd1, rd2;

    ahb_ssram_bridge #(.AW(12), .DW(32), .RD_LAT(g + 1)) u_dut (
      .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel[g]), .HADDR(haddr),
      .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata),
      .HREADY(hreadyout[g]), .HREADYOUT(hreadyout[g]), .HRDATA(hrdata[g]),
      .HRESP(hresp[g]), .sram_addr(s_addr[g]), .sram_en(s_en[g]),
      .sram_we(s_we[g]), .sram_din(s_din[g]), .sram_dout(s_dout[g]),
      .o_dbg_state(dbg_state_unused[g])
    );

    always @(posedge clk) begin
      if (pl_en && pl_sel == 1'(g)) mem[pl_addr] <= pl_data;
      for (int l = 0; l < 4; l++)
        if (s_en[g][l] && s_we[g][l]) mem[s_addr[g][5:0]][l*8 +: 8] <= s_din[g][l*8 +: 8];
      if (|s_en[g] && !(|s_we[g])) rd1 <= mem[s_addr[g][5:0]];
      rd2 <= rd1;
    end
    assign s_dout[g] = (g == 0) ? rd1 : rd2;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];
  logic [7:0]  mdl [2][256];
  int          n_total = 0;
  int          n_bad = 0;
  int          cur = 0;
  int          dp_kind = 0;  // 0 none, 1 read, 2 write, 3 error
  logic [31:0] dp_wdata;
  logic [3:0]  snap_en, snap_we;
  logic [9:0]  snap_addr;
  logic [31:0] snap_din, snap_rdata;
  logic        snap_resp;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_word(input int g, input logic [11:0] a);
    int b;
    b = int'(a[7:2]) * 4;
    return {mdl[g][b+3], mdl[g][b+2], mdl[g][b+1], mdl[g][b]};
  endfunction

  task automatic mdl_write(input int g, input logic [11:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int b;
    for (int i = 0; i < (1 << sz); i++) begin
      b = (int'(a) + i) % 256;
      mdl[g][b] = wd[(b % 4)*8 +: 8];
    end
  endtask

  task automatic check_rst(input string tag, input int g);
    check_val({tag, "_ready"}, hreadyout[g], 1);
    check_val({tag, "_resp"},  hresp[g], 0);
    check_val({tag, "_rdata"}, hrdata[g], 0);
    check_val({tag, "_en"},    s_en[g], 0);
    check_val({tag, "_we"},    s_we[g], 0);
    check_val({tag, "_addr"},  s_addr[g], 0);
    check_val({tag, "_din"},   s_din[g], 0);
  endtask

  // ---------------- driver ----------------
  // Presents one address phase (kind 0 idle, 1 read, 2 write) and checks the
  // data phase of the previous transfer until the address phase is accepted.
  task automatic step(input int kind, input logic [11:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int   ncyc, exp_cyc;
    logic err, rdy;
    err    = (kind != 0) && ((sz > 3'd2) || ((int'(a) % (1 << sz)) != 0));
    hsel   = (cur == 0) ? 2'b01 : 2'b10;
    htrans = (kind != 0) ? 2'b10 : 2'b00;
    hwrite = (kind == 2);
    haddr  = a;
    hsize  = sz;
    hwdata = (dp_kind == 2) ? dp_wdata : $urandom();
    exp_cyc = (dp_kind == 3 || (dp_kind == 1 && cur == 1)) ? 2 : 1;
    ncyc = 0;
    do begin
      @(negedge clk);
      rdy        = hreadyout[cur];
      snap_en    = s_en[cur];
      snap_we    = s_we[cur];
      snap_addr  = s_addr[cur];
      snap_din   = s_din[cur];
      snap_rdata = hrdata[cur];
      snap_resp  = hresp[cur];
      if (dp_kind == 3) begin
        check_val("err_ready", rdy, (ncyc == 1));
        check_val("err_resp", hresp[cur], 1);
        check_val("err_no_sram", s_en[cur], 0);
      end else begin
        check_val("okay_resp", hresp[cur], 0);
        if (rdy && dp_kind == 1) begin
          if (exp_q.size() == 0) check_val("rdata_queue", 0, 1);
          else check_val("rdata", hrdata[cur], exp_q.pop_front());
        end else if (rdy) begin
          check_val("rdata_zero", hrdata[cur], 0);
        end
      end
      @(posedge clk);
      #1;
      ncyc++;
    end while (!rdy && ncyc < 6);
    check_val("wait_cycles", ncyc, exp_cyc);
    if (kind == 0) dp_kind = 0;
    else if (err) dp_kind = 3;
    else if (kind == 1) begin
      dp_kind = 1;
      exp_q.push_back(mdl_word(cur, a));
    end else begin
      dp_kind  = 2;
      dp_wdata = wd;
      mdl_write(cur, a, sz, wd);
    end
  endtask

  task automatic rand_steps(input int n);
    int          kind;
    logic [2:0]  sz;
    logic [11:0] a;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 9);
      kind = (kind < 2) ? 0 : (kind < 6) ? 1 : 2;
      sz   = ($urandom_range(0, 11) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      a    = 12'($urandom_range(0, 63));
      if (sz != 3'd3 && $urandom_range(0, 4) != 0) a = a & ~(12'(1 << sz) - 12'd1);
      if (dp_kind == 3) kind = 0;
      step(kind, a, sz, $urandom());
    end
  endtask

  task automatic flush_compare(input int g);
    int nbad_w;
    nbad_w = 0;
    for (int w = 0; w < 64; w++) begin
      if (g == 0 && g_dut[0].mem[w] !== mdl_word(0, 12'(w * 4))) nbad_w++;
      if (g == 1 && g_dut[1].mem[w] !== mdl_word(1, 12'(w * 4))) nbad_w++;
    end
    check_val(g == 0 ? "flush_mem0" : "flush_mem1", nbad_w, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] d1, d2;
    logic [7:0]  saved [4];
    hsel = 2'b11; htrans = 2'b10; hwrite = 1'b0; haddr = 12'h044;
    hsize = 3'd2; hwdata = 32'hFFFF_FFFF;
    pl_en = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
    for (int g = 0; g < 2; g++) begin
      for (int w = 0; w < 64; w++) begin
        @(negedge clk);
        pl_en = 1'b1; pl_sel = g[0]; pl_addr = w[5:0];
        pl_data = $urandom();
        if (g == 0 && w == 1) pl_data = 32'h1111_1111;
        if (g == 1 && w == 2) pl_data = 32'h1234_5678;
        for (int l = 0; l < 4; l++) mdl[g][w*4 + l] = pl_data[l*8 +: 8];
      end
    end
    @(negedge clk);
    pl_en = 1'b0;
    check_rst("reset0", 0);
    check_rst("reset1", 1);
    rst_n = 1'b1;
    htrans = 2'b00; hsel = 2'b00;
    @(posedge clk);
    #1;

    // word write then immediate read of the same word
    cur = 0;
    step(2, 12'h004, 3'd2, 32'hDEAD_BEEF);
    step(1, 12'h004, 3'd2, 32'h0);
    check_val("fwd_rd_en", snap_en, 4'hF);
    check_val("fwd_rd_we", snap_we, 4'h0);
    check_val("fwd_rd_addr", snap_addr, 10'h001);
    step(0, 12'h0, 3'd0, 32'h0);
    check_val("fwd_rdata", snap_rdata, 32'hDEAD_BEEF);
    check_val("fwd_commit_we", snap_we, 4'hF);
    check_val("fwd_commit_addr", snap_addr, 10'h001);
    check_val("fwd_commit_din", snap_din, 32'hDEAD_BEEF);

    // byte write on the top lane
    step(2, 12'h013, 3'd0, 32'hAA00_0000);
    step(0, 12'h0, 3'd0, 32'h0);
    check_val("byte_en", snap_en, 4'b1000);
    check_val("byte_we", snap_we, 4'b1000);
    check_val("byte_addr", snap_addr, 10'h004);
    check_val("byte_din", snap_din[31:24], 8'hAA);

    // misaligned word transfer, then a legal read
    step(1, 12'h002, 3'd2, 32'h0);
    check_val("err_addr_no_sram", snap_en, 4'h0);
    step(0, 12'h0, 3'd0, 32'h0);
    step(1, 12'h008, 3'd2, 32'h0);
    step(0, 12'h0, 3'd0, 32'h0);
    check_val("after_err_resp", snap_resp, 1'b0);

    // buffered write held across four reads, committing in the idle cycle
    d1 = $urandom();
    step(2, 12'h020, 3'd2, d1);
    for (int i = 0; i < 4; i++) begin
      step(1, 12'h040, 3'd2, 32'h0);
      check_val("held_no_we", snap_we, 4'h0);
    end
    step(0, 12'h0, 3'd0, 32'h0);
    check_val("held_commit_we", snap_we, 4'hF);
    check_val("held_commit_addr", snap_addr, 10'h008);
    check_val("held_commit_din", snap_din, d1);

    // same sequence with reset pulsed before the idle cycle
    for (int l = 0; l < 4; l++) saved[l] = mdl[0][32 + l];
    d2 = ~d1;
    step(2, 12'h020, 3'd2, d2);
    for (int i = 0; i < 4; i++) step(1, 12'h040, 3'd2, 32'h0);
    rst_n = 1'b0;
    htrans = 2'b00;
    #2;
    check_rst("midrst0", 0);
    check_rst("midrst1", 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    dp_kind = 0;
    for (int l = 0; l < 4; l++) mdl[0][32 + l] = saved[l];
    step(0, 12'h0, 3'd0, 32'h0);
    check_val("rst_no_commit_we", snap_we, 4'h0);
    check_val("rst_mem_kept", g_dut[0].mem[8], d1);

    rand_steps(400);
    for (int i = 0; i < 3; i++) step(0, 12'h0, 3'd0, 32'h0);

    // two-cycle read latency instance
    cur = 1;
    step(0, 12'h0, 3'd0, 32'h0);
    step(1, 12'h008, 3'd2, 32'h0);
    step(0, 12'h0, 3'd0, 32'h0);
    check_val("lat2_rdata", snap_rdata, 32'h1234_5678);
    rand_steps(400);
    for (int i = 0; i < 3; i++) step(0, 12'h0, 3'd0, 32'h0);

    flush_compare(0);
    flush_compare(1);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
